dsp_chain_sop2_acc: RTL and testbench
=====================================

Name: dsp_chain_sop2_acc

Overview:
- Parametrised successor to the fixed 4-stage sum-of-two-products DSP chain.
- NUM_STAGES cascaded stages. Each stage adds top_a*top_b + bot_a*bot_b (signed integer) to the incoming chain value.
- Stage inputs are skewed internally, so a whole vector is presented in one cycle.
- Adds valid tracking, a pipelined accumulate mode and a sticky overflow flag. Used as a dot-product/MAC proxy tile.

Parameters:
- NUM_STAGES, 4: number of chained sop2 stages (>=1).
- DATA_W, 16: width of each signed operand.
- ACC_W, 40: chain/accumulator width. Must satisfy ACC_W >= 2*DATA_W + clog2(2*NUM_STAGES) + 1, so the chain itself never overflows.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input vector valid this cycle
- acc_en  in  1  1: add dot product to accumulator; 0: load it
- top_a  in  NUM_STAGES*DATA_W  stage k operand in bits [k*DATA_W +: DATA_W], signed
- top_b  in  NUM_STAGES*DATA_W  as top_a
- bot_a  in  NUM_STAGES*DATA_W  as top_a
- bot_b  in  NUM_STAGES*DATA_W  as top_a
- result  out  ACC_W  accumulator value, signed
- out_valid  out  1  result updated this cycle
- overflow  out  1  sticky signed-overflow flag of the current accumulation

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset: result=0, out_valid=0, overflow=0. All skew, chain, valid and acc_en tag registers are cleared.
- Reset asserted mid-operation discards all in-flight vectors; no out_valid is produced for them.
- Input capture: on an edge with in_valid=1, all four operand buses and acc_en are sampled as one vector.
- Skew: stage k's operands pass through k delay registers, so they meet the chain value from stage k-1.
- Stage k registers chain_k = chain_{k-1} + top_a_k*top_b_k + bot_a_k*bot_b_k.
  - chain_{-1} = 0.
  - Products are full signed 2*DATA_W, sign-extended to ACC_W.
- Valid/tag pipeline: in_valid and acc_en travel alongside the chain, one register per stage.
- Final stage: dot = chain_{N-1}. It is processed in the accumulator register on the next edge:
  - tag acc_en=0: result <= dot; overflow <= 0.
  - tag acc_en=1: result <= result + dot, wrapping modulo 2^ACC_W. overflow <= overflow | signed_ovf, where signed_ovf means both operands share a sign and the sum's sign differs.
- Latency: a vector sampled at edge E produces out_valid=1 and its result after edge E+NUM_STAGES+1.
- Throughput: one vector per cycle. Bubbles (in_valid=0) propagate as out_valid=0 with the same spacing.
- On cycles with out_valid=0, result and overflow hold their values.
- acc_en=1 on the first vector after reset accumulates onto 0 (legal).
- Operands with in_valid=0 are don't-care and must not affect result.
- Simultaneous reset and in_valid: reset wins; the vector is dropped.

Test Plan (NUM_STAGES=4, DATA_W=16, ACC_W=40):
1. Reset: assert reset 2 cycles with random inputs and in_valid=1 -> result=0, out_valid=0, overflow=0 throughout and for 5 cycles after release with in_valid=0.
2. Single vector: all lanes top_a=2, top_b=3, bot_a=4, bot_b=5, acc_en=0 at edge E -> out_valid=1 only after E+5, result=104, overflow=0.
3. Back-to-back accumulate: three consecutive vectors with dots 104, -10, 7 and acc_en=0,1,1 -> results 104, 94, 101 on three consecutive cycles.
4. Signed extremes: all operands -32768, acc_en=0 -> result=8589934592 (2^33), overflow=0. Then all operands top_a=-32768, top_b=32767 -> result=-8589672448.
5. Overflow: vector of case 4 with acc_en=0, then 63 identical vectors with acc_en=1 -> 64th result=-549755813888 (wrap), overflow=1. The next vector with acc_en=0 and dot 104 -> result=104, overflow=0.
6. Bubbles and reset mid-flight:
   - in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 five edges later.
   - Separately, vector at edge E with reset at E+2 -> no out_valid for that vector; result stays 0.

Source files
------------

// File: rtl/dsp_chain_sop2_acc.sv
// dsp_chain_sop2_acc: chain of signed sum-of-two-products stages with skewed operands,
// valid/tag pipeline and a wrapping accumulator with sticky signed overflow.
module dsp_chain_sop2_acc #(
   parameter int NUM_STAGES = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W = 40
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         acc_en,
   input  logic [NUM_STAGES*DATA_W-1:0] top_a,
   input  logic [NUM_STAGES*DATA_W-1:0] top_b,
   input  logic [NUM_STAGES*DATA_W-1:0] bot_a,
   input  logic [NUM_STAGES*DATA_W-1:0] bot_b,
   output logic [ACC_W-1:0]             result,
   output logic                         out_valid,
   output logic                         overflow
);
   localparam int PW = 2 * DATA_W;
   logic in_vld_q, in_tag_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         in_vld_q <= 1'b0;
         in_tag_q <= 1'b0;
      end else begin
         in_vld_q <= in_valid;
         in_tag_q <= acc_en;
      end
   end
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      // slot 0 is the input capture register; stage k sees slot k
      logic signed [DATA_W-1:0] ta [k+1];
      logic signed [DATA_W-1:0] tb [k+1];
      logic signed [DATA_W-1:0] ba [k+1];
      logic signed [DATA_W-1:0] bb [k+1];
      logic signed [PW-1:0]     p_top, p_bot;
      logic [ACC_W-1:0]         prev, chain_q;
      logic                     prev_vld, prev_tag, vld_q, tag_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int j = 0; j <= k; j++) begin
               ta[j] <= '0;
               tb[j] <= '0;
               ba[j] <= '0;
               bb[j] <= '0;
            end
         end else begin
            ta[0] <= top_a[k*DATA_W +: DATA_W];
            tb[0] <= top_b[k*DATA_W +: DATA_W];
            ba[0] <= bot_a[k*DATA_W +: DATA_W];
            bb[0] <= bot_b[k*DATA_W +: DATA_W];
            for (int j = 1; j <= k; j++) begin
               ta[j] <= ta[j-1];
               tb[j] <= tb[j-1];
               ba[j] <= ba[j-1];
               bb[j] <= bb[j-1];
            end
         end
      end
      if (k == 0) begin : g_first
         assign prev     = '0;
         assign prev_vld = in_vld_q;
         assign prev_tag = in_tag_q;
      end else begin : g_next
         assign prev     = g_stage[k-1].chain_q;
         assign prev_vld = g_stage[k-1].vld_q;
         assign prev_tag = g_stage[k-1].tag_q;
      end
      assign p_top = PW'(ta[k]) * PW'(tb[k]);
      assign p_bot = PW'(ba[k]) * PW'(bb[k]);
      always_ff @(posedge clk) begin
         if (reset) begin
            chain_q <= '0;
            vld_q   <= 1'b0;
            tag_q   <= 1'b0;
         end else begin
            chain_q <= prev + ACC_W'(p_top) + ACC_W'(p_bot);
            vld_q   <= prev_vld;
            tag_q   <= prev_tag;
         end
      end
   end
   logic [ACC_W-1:0] dot, sum;
   logic             last_vld, last_tag, ovf;
   assign dot      = g_stage[NUM_STAGES-1].chain_q;
   assign last_vld = g_stage[NUM_STAGES-1].vld_q;
   assign last_tag = g_stage[NUM_STAGES-1].tag_q;
   assign sum      = result + dot;
   assign ovf      = (result[ACC_W-1] == dot[ACC_W-1]) && (sum[ACC_W-1] != result[ACC_W-1]);
   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         out_valid <= last_vld;
         if (last_vld) begin
            result   <= last_tag ? sum : dot;
            overflow <= last_tag ? (overflow | ovf) : 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dsp_chain_sop2_acc.sv
// tb_dsp_chain_sop2_acc: directed and random stimulus checked against a queue-based
// dot-product/accumulator model plus hand-computed literal expectations.
module tb_dsp_chain_sop2_acc;
   localparam int N = 4, DW = 16, AW = 40, BW = N * DW;
   localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (AW - 1));
   logic clk = 1'b0;
   logic reset, in_valid, acc_en;
   logic [BW-1:0] top_a, top_b, bot_a, bot_b;
   logic [AW-1:0] result;
   logic out_valid, overflow;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   dsp_chain_sop2_acc #(.NUM_STAGES(N), .DATA_W(DW), .ACC_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .acc_en(acc_en),
      .top_a(top_a), .top_b(top_b), .bot_a(bot_a), .bot_b(bot_b),
      .result(result), .out_valid(out_valid), .overflow(overflow)
   );
   typedef struct { int due; longint dot; bit acc; } ent_t;
   ent_t pend[$];
   ent_t e;
   int cyc = 0;
   bit live = 0;
   bit r_s, v_s, a_s, m_vld, m_ovf;
   logic [BW-1:0] ta_s, tb_s, ba_s, bb_s;
   logic signed [AW-1:0] m_res = '0;
   longint s;
   task automatic chk(string name, longint got, longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask
   function automatic longint dot_of(logic [BW-1:0] ta, logic [BW-1:0] tb, logic [BW-1:0] ba, logic [BW-1:0] bb);
      longint acc = 0;
      for (int i = 0; i < N; i++)
         acc += longint'($signed(ta[i*DW +: DW])) * longint'($signed(tb[i*DW +: DW]))
              + longint'($signed(ba[i*DW +: DW])) * longint'($signed(bb[i*DW +: DW]));
      return acc;
   endfunction
   function automatic logic [BW-1:0] rep(logic [DW-1:0] x);
      return {N{x}};
   endfunction
   function automatic logic [BW-1:0] rnd();
      return BW'({$urandom(), $urandom()});
   endfunction
   // reference model: each accepted vector becomes due N+1 edges after it is sampled
   initial forever begin
      @(posedge clk);
      r_s = reset; v_s = in_valid; a_s = acc_en;
      ta_s = top_a; tb_s = top_b; ba_s = bot_a; bb_s = bot_b;
      #1;
      cyc++;
      if (r_s) begin
         pend.delete();
         m_res = '0; m_ovf = 0; m_vld = 0; live = 1;
      end else begin
         m_vld = 0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            m_vld = 1;
            s = longint'(m_res) + e.dot;
            if (e.acc) begin
               m_ovf = m_ovf | (s > MAXV) | (s < MINV);
               m_res = AW'(s);
            end else begin
               m_ovf = 0;
               m_res = AW'(e.dot);
            end
         end
         if (v_s) pend.push_back('{due: cyc + N + 1, dot: dot_of(ta_s, tb_s, ba_s, bb_s), acc: a_s});
      end
      if (live) begin
         chk("out_valid", longint'(out_valid), longint'(m_vld));
         chk("result", longint'($signed(result)), longint'(m_res));
         chk("overflow", longint'(overflow), longint'(m_ovf));
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic idle();
      in_valid = 0; acc_en = 1'($urandom);
      top_a = rnd(); top_b = rnd(); bot_a = rnd(); bot_b = rnd();
   endtask
   task automatic put(bit v, bit a, logic [BW-1:0] ta, logic [BW-1:0] tb, logic [BW-1:0] ba, logic [BW-1:0] bb);
      in_valid = v; acc_en = a; top_a = ta; top_b = tb; bot_a = ba; bot_b = bb;
      tick();
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #3;
         n++;
      end while (!out_valid && n < 20);
   endtask
   task automatic lit(string name, longint exp_res, longint exp_ovf);
      chk({name, "_vld"}, longint'(out_valid), 1);
      chk({name, "_res"}, longint'($signed(result)), exp_res);
      chk({name, "_ovf"}, longint'(overflow), exp_ovf);
      chk({name, "_model"}, longint'(m_res), exp_res);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   int n;
   logic [BW-1:0] mn, mx;
   initial begin
      mn = rep(16'h8000); mx = rep(16'h7fff);
      reset = 1;
      in_valid = 1; acc_en = 1; top_a = rnd(); top_b = rnd(); bot_a = rnd(); bot_b = rnd();
      tick();
      top_a = rnd(); top_b = rnd(); bot_a = rnd(); bot_b = rnd();
      tick();
      chk("rst_res", longint'(result), 0);
      reset = 0;
      idle();
      repeat (5) begin
         tick();
         chk("post_rst_vld", longint'(out_valid), 0);
         chk("post_rst_res", longint'(result), 0);
         chk("post_rst_ovf", longint'(overflow), 0);
      end
      put(1, 0, rep(2), rep(3), rep(4), rep(5));
      idle();
      wait_valid(n);
      chk("single_lat", n, 5);
      lit("single", 104, 0);
      put(1, 0, rep(2), rep(3), rep(4), rep(5));
      put(1, 1, {48'd0, 16'hfff6}, {48'd0, 16'd1}, '0, '0);
      put(1, 1, {48'd0, 16'd7}, {48'd0, 16'd1}, '0, '0);
      idle();
      wait_valid(n);
      chk("b2b_lat", n, 3);
      lit("b2b0", 104, 0);
      wait_valid(n);
      chk("b2b1_gap", n, 1);
      lit("b2b1", 94, 0);
      wait_valid(n);
      chk("b2b2_gap", n, 1);
      lit("b2b2", 101, 0);
      put(1, 0, mn, mn, mn, mn);
      idle();
      wait_valid(n);
      lit("ext_min", 64'sd8589934592, 0);
      put(1, 0, mn, mx, mn, mx);
      idle();
      wait_valid(n);
      lit("ext_mix", -64'sd8589672448, 0);
      put(1, 0, mn, mn, mn, mn);
      repeat (63) put(1, 1, mn, mn, mn, mn);
      idle();
      repeat (5) @(posedge clk);
      #3;
      lit("ovf_wrap", -64'sd549755813888, 1);
      put(1, 0, rep(2), rep(3), rep(4), rep(5));
      idle();
      wait_valid(n);
      lit("ovf_clear", 104, 0);
      put(1, 0, rep(2), rep(3), rep(4), rep(5));
      idle();
      tick();
      put(1, 0, rep(1), rep(1), '0, '0);
      idle();
      wait_valid(n);
      chk("bub_lat", n, 3);
      lit("bub0", 104, 0);
      @(posedge clk);
      #3;
      chk("bub_gap_vld", longint'(out_valid), 0);
      @(posedge clk);
      #3;
      lit("bub1", 4, 0);
      reset = 1;
      tick();
      reset = 0;
      put(1, 0, rep(2), rep(3), rep(4), rep(5));
      idle();
      tick();
      reset = 1;
      tick();
      reset = 0;
      repeat (8) begin
         tick();
         chk("flush_vld", longint'(out_valid), 0);
         chk("flush_res", longint'(result), 0);
      end
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(59) == 0);
         in_valid = ($urandom_range(3) != 0);
         acc_en = ($urandom_range(4) != 0);
         if ($urandom_range(3) == 0) begin
            top_a = mn; top_b = mn; bot_a = mn; bot_b = mn;
         end else begin
            top_a = rnd(); top_b = rnd(); bot_a = rnd(); bot_b = rnd();
         end
         tick();
      end
      reset = 0;
      idle();
      repeat (10) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
